// File: rtl/dircc_avalon_st_sink_pkg.sv
// Shared constants for the Avalon-ST sink monitor.
// Register map, status bit positions, FSM encoding, MODE values.
package dircc_avalon_st_sink_pkg;

  localparam logic [1:0] ADDR_STATUS     = 2'd0;
  localparam logic [1:0] ADDR_PKT_COUNT  = 2'd1;
  localparam logic [1:0] ADDR_BEAT_COUNT = 2'd2;
  localparam logic [1:0] ADDR_CAPTURE    = 2'd3;

  localparam int STS_UNEXPECTED = 15;
  localparam int STS_FRAME_ERR  = 14;
  localparam int STS_OVERFLOW   = 13;
  localparam int STS_IN_PKT     = 0;

  localparam int MODE_STRICT   = 0;
  localparam int MODE_COUNTING = 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } frame_state_e;

  function automatic logic [31:0] status_word(
    input logic unexp,
    input logic frame_err,
    input logic ovf,
    input logic in_pkt
  );
    logic [31:0] w;
    w = '0;
    w[STS_UNEXPECTED] = unexp;
    w[STS_FRAME_ERR]  = frame_err;
    w[STS_OVERFLOW]   = ovf;
    w[STS_IN_PKT]     = in_pkt;
    return w;
  endfunction

endpackage

// File: rtl/dircc_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Increment beats clear; increment at all-ones pulses overflow.
module dircc_sat_counter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inc,
  input  logic                   clr,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow
);

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  assign count = count_q;

  // next count: clear, then increment (clear+inc reads 1)
  always_comb begin
    count_d  = count_q;
    overflow = 1'b0;
    if (clr) begin
      count_d = '0;
    end
    if (inc) begin
      if (clr) begin
        count_d = COUNT_WIDTH'(1);
      end else if (&count_q) begin
        overflow = 1'b1;
      end else begin
        count_d = count_q + COUNT_WIDTH'(1);
      end
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dircc_avalon_st_sink_monitor.sv
// Avalon-ST sink that checks framing and counts packets/beats.
// Optional first-beat capture: define DIRCC_ST_SINK_CAPTURE_EN.
module dircc_avalon_st_sink_monitor
  import dircc_avalon_st_sink_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2,
  parameter int COUNT_WIDTH = 16,
  parameter int MODE        = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [EMPTY_WIDTH-1:0] in_empty,
  input  logic                   in_startofpacket,
  input  logic                   in_endofpacket,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             csr_address,
  input  logic                   csr_read,
  input  logic                   csr_write,
  input  logic [31:0]            csr_writedata,
  output logic [31:0]            csr_readdata,
  output logic                   irq
);

  localparam logic STRICT = (MODE == MODE_STRICT);

  logic         ready_q, ready_d;
  frame_state_e state_q, state_d;
  logic         unexp_q, unexp_d;
  logic         frame_q, frame_d;
  logic         ovf_q, ovf_d;
  logic         irq_q, irq_d;
  logic [31:0]  rdata_q, rdata_d;

  logic accept;
  logic pkt_done;
  logic frame_set;
  logic sts_wr;
  logic pkt_clr;
  logic beat_clr;
  logic pkt_ovf;
  logic beat_ovf;
  logic [COUNT_WIDTH-1:0] pkt_count;
  logic [COUNT_WIDTH-1:0] beat_count;
  logic [31:0] sts_word;
  logic [31:0] cap_word;
  logic unused_in;

  assign in_ready     = ready_q;
  assign csr_readdata = rdata_q;
  assign irq          = irq_q;

  assign accept   = in_valid & ready_q;
  assign sts_wr   = csr_write & (csr_address == ADDR_STATUS);
  assign pkt_clr  = csr_write & (csr_address == ADDR_PKT_COUNT);
  assign beat_clr = csr_write & (csr_address == ADDR_BEAT_COUNT);

  assign unused_in = ^{in_empty, in_data,
                       csr_writedata[31:16],
                       csr_writedata[12:0]};

  assign sts_word = status_word(unexp_q, frame_q, ovf_q,
                                state_q == ST_IN_PKT);

  dircc_sat_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_pkt_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc     (pkt_done),
    .clr     (pkt_clr),
    .count   (pkt_count),
    .overflow(pkt_ovf)
  );

  dircc_sat_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_beat_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc     (accept),
    .clr     (beat_clr),
    .count   (beat_count),
    .overflow(beat_ovf)
  );

  // framing FSM: next state, packet-complete and framing-error pulses
  always_comb begin
    state_d   = state_q;
    pkt_done  = 1'b0;
    frame_set = 1'b0;
    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_startofpacket) begin
            if (in_endofpacket) begin
              pkt_done = 1'b1;
            end else begin
              state_d = ST_IN_PKT;
            end
          end else begin
            frame_set = 1'b1;
          end
        end
        ST_IN_PKT: begin
          if (in_startofpacket) begin
            frame_set = 1'b1;
          end
          if (in_endofpacket) begin
            pkt_done = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      endcase
    end
  end

  // sticky status bits: W1C, with set taking priority
  always_comb begin
    ready_d = 1'b1;
    unexp_d = unexp_q;
    frame_d = frame_q;
    ovf_d   = ovf_q;
    if (sts_wr && csr_writedata[STS_UNEXPECTED]) begin
      unexp_d = 1'b0;
    end
    if (sts_wr && csr_writedata[STS_FRAME_ERR]) begin
      frame_d = 1'b0;
    end
    if (sts_wr && csr_writedata[STS_OVERFLOW]) begin
      ovf_d = 1'b0;
    end
    if (accept && STRICT) begin
      unexp_d = 1'b1;
    end
    if (frame_set) begin
      frame_d = 1'b1;
    end
    if (pkt_ovf || beat_ovf) begin
      ovf_d = 1'b1;
    end
    irq_d = unexp_q | frame_q | ovf_q;
  end

  // CSR read mux, registered; holds when not reading
  always_comb begin
    rdata_d = rdata_q;
    if (csr_read) begin
      unique case (csr_address)
        ADDR_STATUS:     rdata_d = sts_word;
        ADDR_PKT_COUNT:  rdata_d = 32'(pkt_count);
        ADDR_BEAT_COUNT: rdata_d = 32'(beat_count);
        ADDR_CAPTURE:    rdata_d = cap_word;
      endcase
    end
  end

  // control and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      state_q <= ST_IDLE;
      unexp_q <= 1'b0;
      frame_q <= 1'b0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= ready_d;
      state_q <= state_d;
      unexp_q <= unexp_d;
      frame_q <= frame_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef DIRCC_ST_SINK_CAPTURE_EN
  logic [31:0] cap_q, cap_d;
  logic        armed_q, armed_d;

  assign cap_word = cap_q;

  // grab first accepted beat; status write re-arms
  always_comb begin
    cap_d   = cap_q;
    armed_d = armed_q;
    if (accept && armed_q) begin
      cap_d   = 32'(in_data);
      armed_d = 1'b0;
    end
    if (sts_wr) begin
      armed_d = 1'b1;
    end
  end

  // capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      cap_q   <= cap_d;
      armed_q <= armed_d;
    end
  end
`else
  assign cap_word = '0;
`endif

endmodule

// File: tb/tb_dircc_avalon_st_sink_monitor.sv
// Directed bench: MODE 0, MODE 1 and 4-bit-counter sinks
// share one stimulus stream; expectations are hand-computed.
module tb_dircc_avalon_st_sink_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [1:0]  in_empty;
  logic        sop, eop, valid;
  logic [1:0]  addr;
  logic        rd, wr;
  logic [31:0] wdata;

  logic        rdy0, rdy1, rdy4;
  logic [31:0] rd0, rd1, rd4;
  logic        irq0, irq1, irq4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dircc_avalon_st_sink_monitor #(.MODE(0)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data),
    .in_empty(in_empty), .in_startofpacket(sop),
    .in_endofpacket(eop), .in_valid(valid),
    .in_ready(rdy0), .csr_address(addr), .csr_read(rd),
    .csr_write(wr), .csr_writedata(wdata),
    .csr_readdata(rd0), .irq(irq0)
  );

  dircc_avalon_st_sink_monitor #(.MODE(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data),
    .in_empty(in_empty), .in_startofpacket(sop),
    .in_endofpacket(eop), .in_valid(valid),
    .in_ready(rdy1), .csr_address(addr), .csr_read(rd),
    .csr_write(wr), .csr_writedata(wdata),
    .csr_readdata(rd1), .irq(irq1)
  );

  dircc_avalon_st_sink_monitor #(.MODE(1), .COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .in_data(in_data),
    .in_empty(in_empty), .in_startofpacket(sop),
    .in_endofpacket(eop), .in_valid(valid),
    .in_ready(rdy4), .csr_address(addr), .csr_read(rd),
    .csr_write(wr), .csr_writedata(wdata),
    .csr_readdata(rd4), .irq(irq4)
  );

  typedef struct {
    logic        s0, e0, s1, e1;
    logic [31:0] sts;
    logic [31:0] pkts;
    logic [31:0] beats;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, act, exp);
    end
  endtask

  // every task starts and ends just after a falling edge
  task automatic idle_inputs();
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = 2'd0; wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic beat(input logic s, input logic e,
                      input logic [31:0] d);
    valid = 1'b1; sop = s; eop = e; in_data = d;
    @(negedge clk);
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a);
    rd = 1'b1; addr = a;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic csr_wr(input logic [1:0] a,
                        input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0; wdata = '0;
  endtask

  logic [31:0] held;
  logic [31:0] cap_exp0, cap_exp1;

  initial begin
    tbl[0] = '{1, 1, 1, 1, 32'h0000, 32'd2, 32'd2};
    tbl[1] = '{1, 0, 0, 1, 32'h0000, 32'd1, 32'd2};
    tbl[2] = '{0, 0, 1, 1, 32'h4000, 32'd1, 32'd2};
    tbl[3] = '{1, 0, 1, 0, 32'h4001, 32'd0, 32'd2};
    tbl[4] = '{1, 0, 1, 1, 32'h4000, 32'd1, 32'd2};
    tbl[5] = '{1, 0, 0, 0, 32'h0001, 32'd0, 32'd2};
    tbl[6] = '{0, 1, 0, 1, 32'h4000, 32'd0, 32'd2};

`ifdef DIRCC_ST_SINK_CAPTURE_EN
    cap_exp0 = 32'hDEAD_BEEF;
    cap_exp1 = 32'hCAFE_F00D;
`else
    cap_exp0 = 32'h0;
    cap_exp1 = 32'h0;
`endif

    in_data = '0;
    in_empty = '0;
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // reset values
    chk("ready_in_reset", 32'(rdy0), 32'd0);
    chk("rdata_in_reset", rd0, 32'h0);
    chk("irq_in_reset", 32'(irq0), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(rdy0), 32'd1);
    repeat (5) @(negedge clk);
    chk("ready_held", 32'(rdy1), 32'd1);
    csr_rd(2'd0);
    chk("status_idle", rd0, 32'h0);
    chk("irq_idle", 32'(irq0), 32'd0);

    // two-beat framing table
    for (int i = 0; i < 7; i++) begin
      do_reset();
      beat(tbl[i].s0, tbl[i].e0, 32'h0);
      beat(tbl[i].s1, tbl[i].e1, 32'h0);
      csr_rd(2'd0);
      chk($sformatf("tbl%0d_sts_m1", i), rd1, tbl[i].sts);
      chk($sformatf("tbl%0d_sts_m0", i), rd0,
          tbl[i].sts | 32'h8000);
      csr_rd(2'd1);
      chk($sformatf("tbl%0d_pkts", i), rd1, tbl[i].pkts);
      csr_rd(2'd2);
      chk($sformatf("tbl%0d_beats", i), rd1, tbl[i].beats);
    end

    // three well-formed 4-beat packets
    do_reset();
    for (int p = 0; p < 3; p++) begin
      beat(1'b1, 1'b0, 32'h0);
      beat(1'b0, 1'b0, 32'h0);
      beat(1'b0, 1'b0, 32'h0);
      beat(1'b0, 1'b1, 32'h0);
    end
    csr_rd(2'd1);
    chk("m1_3pkt_pkts", rd1, 32'd3);
    csr_rd(2'd2);
    chk("m1_3pkt_beats", rd1, 32'd12);
    csr_rd(2'd0);
    chk("m1_3pkt_sts", rd1, 32'h0);
    chk("m0_3pkt_sts", rd0, 32'h8000);

    // strict mode, single beat, irq timing and W1C
    do_reset();
    beat(1'b1, 1'b1, 32'h0);
    chk("irq_lag1", 32'(irq0), 32'd0);
    @(negedge clk);
    chk("irq_lag2", 32'(irq0), 32'd1);
    chk("irq_m1_quiet", 32'(irq1), 32'd0);
    csr_rd(2'd0);
    chk("m0_unexp_sts", rd0, 32'h8000);
    held = rd0;
    repeat (2) @(negedge clk);
    chk("rdata_hold", rd0, held);
    csr_wr(2'd0, 32'h8000);
    @(negedge clk);
    chk("irq_cleared", 32'(irq0), 32'd0);
    csr_rd(2'd0);
    chk("m0_sts_cleared", rd0, 32'h0);

    // SOP, SOP, EOP
    do_reset();
    beat(1'b1, 1'b0, 32'h0);
    beat(1'b1, 1'b0, 32'h0);
    beat(1'b0, 1'b1, 32'h0);
    csr_rd(2'd0);
    chk("sse_sts", rd1, 32'h4000);
    csr_rd(2'd1);
    chk("sse_pkts", rd1, 32'd1);
    csr_rd(2'd2);
    chk("sse_beats", rd1, 32'd3);
    chk("sse_irq", 32'(irq1), 32'd1);

    // reset mid-packet abandons silently
    do_reset();
    beat(1'b1, 1'b0, 32'h0);
    do_reset();
    csr_rd(2'd0);
    chk("midpkt_rst_sts", rd1, 32'h0);
    csr_rd(2'd1);
    chk("midpkt_rst_pkts", rd1, 32'h0);

    // saturation with a 4-bit counter
    do_reset();
    for (int k = 0; k < 17; k++) begin
      beat(1'b1, 1'b1, 32'h0);
    end
    csr_rd(2'd1);
    chk("sat_pkts_w4", rd4, 32'd15);
    chk("sat_pkts_w16", rd1, 32'd17);
    csr_rd(2'd0);
    chk("sat_sts_w4", rd4, 32'h2000);
    chk("sat_sts_w16", rd1, 32'h0);
    chk("sat_irq_w4", 32'(irq4), 32'd1);
    wr = 1'b1; addr = 2'd1; wdata = 32'hFFFF_FFFF;
    beat(1'b1, 1'b1, 32'h0);
    wr = 1'b0;
    csr_rd(2'd1);
    chk("clr_inc_w4", rd4, 32'd1);
    chk("clr_inc_w16", rd1, 32'd1);
    csr_rd(2'd2);
    chk("sat_beats_w4", rd4, 32'd15);
    chk("beats_w16", rd1, 32'd18);

    // first-beat capture
    do_reset();
    beat(1'b1, 1'b0, 32'hDEAD_BEEF);
    beat(1'b0, 1'b1, 32'h1234_5678);
    csr_rd(2'd3);
    chk("capture_first", rd1, cap_exp0);
    csr_wr(2'd0, 32'h0);
    beat(1'b1, 1'b1, 32'hCAFE_F00D);
    beat(1'b1, 1'b1, 32'h1111_1111);
    csr_rd(2'd3);
    chk("capture_rearm", rd0, cap_exp1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
